// File: rtl/decode_queue.sv
// decode_queue: RV32I/Zicsr/M decode stage with a DEPTH-entry buffer.
// Instructions are decoded on entry and execute reads registered control.
module decode_queue #(
  parameter int DEPTH    = 2,
  parameter int PC_WIDTH = 32,
  parameter int HAS_M    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_ins,
  input  logic [PC_WIDTH-1:0]        in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [31:0]                out_ins,
  output logic [3:0]                 out_class,
  output logic [4:0]                 out_alu_op,
  output logic [31:0]                out_imm,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [2:0]                 out_funct3,
  output logic                       out_rd_wen,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [3:0] C_OP     = 4'd0;
  localparam logic [3:0] C_OPIMM  = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_JAL    = 4'd5;
  localparam logic [3:0] C_JALR   = 4'd6;
  localparam logic [3:0] C_LUI    = 4'd7;
  localparam logic [3:0] C_AUIPC  = 4'd8;
  localparam logic [3:0] C_CSR    = 4'd9;
  localparam logic [3:0] C_SYS    = 4'd10;
  localparam logic [3:0] C_FENCE  = 4'd11;
  localparam logic [3:0] C_MULDIV = 4'd12;
  localparam logic [3:0] C_ILL    = 4'd15;

  localparam logic [4:0] A_ADD = 5'd0;
  localparam logic [4:0] A_SUB = 5'd1;
  localparam logic [4:0] A_SLL = 5'd2;
  localparam logic [4:0] A_SRL = 5'd3;
  localparam logic [4:0] A_SRA = 5'd4;
  localparam logic [4:0] A_LT  = 5'd5;
  localparam logic [4:0] A_LTU = 5'd6;
  localparam logic [4:0] A_XOR = 5'd7;
  localparam logic [4:0] A_OR  = 5'd8;
  localparam logic [4:0] A_AND = 5'd9;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         ins;
    logic [3:0]          cls;
    logic [4:0]          alu;
    logic [31:0]         imm;
    logic                rd_wen;
    logic                illegal;
  } entry_t;

  function automatic logic [4:0] alu_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [4:0] r;
    r = A_ADD;
    unique case (f3)
      3'd0: r = alt ? A_SUB : A_ADD;
      3'd1: r = A_SLL;
      3'd2: r = A_LT;
      3'd3: r = A_LTU;
      3'd4: r = A_XOR;
      3'd5: r = alt ? A_SRA : A_SRL;
      3'd6: r = A_OR;
      3'd7: r = A_AND;
      default: r = A_ADD;
    endcase
    return r;
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] f12;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc = in_ins[6:0];
  assign f3  = in_ins[14:12];
  assign f7  = in_ins[31:25];
  assign f12 = in_ins[31:20];
  assign rs1 = in_ins[19:15];
  assign rd  = in_ins[11:7];

  assign imm_i = {{20{in_ins[31]}}, in_ins[31:20]};
  assign imm_s = {{20{in_ins[31]}}, in_ins[31:25],
                  in_ins[11:7]};
  assign imm_b = {{20{in_ins[31]}}, in_ins[7],
                  in_ins[30:25], in_ins[11:8], 1'b0};
  assign imm_u = {in_ins[31:12], 12'b0};
  assign imm_j = {{12{in_ins[31]}}, in_ins[19:12],
                  in_ins[20], in_ins[30:21], 1'b0};

  entry_t dec;
  logic   ok;

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.ins = in_ins;
    ok      = 1'b0;
    unique case (opc)
      7'b0110011: begin
        dec.rd_wen = 1'b1;
        dec.cls    = C_OP;
        if (f7 == 7'h00) begin
          ok      = 1'b1;
          dec.alu = alu_f3(f3, 1'b0);
        end else if (f7 == 7'h20 &&
                     (f3 == 3'd0 || f3 == 3'd5)) begin
          ok      = 1'b1;
          dec.alu = alu_f3(f3, 1'b1);
        end else if (f7 == 7'h01 && HAS_M != 0) begin
          ok      = 1'b1;
          dec.cls = C_MULDIV;
          dec.alu = {2'b10, f3};
        end
      end
      7'b0010011: begin
        dec.cls    = C_OPIMM;
        dec.rd_wen = 1'b1;
        dec.imm    = imm_i;
        dec.alu    = alu_f3(f3, f3 == 3'd5 && f7 == 7'h20);
        if (f3 == 3'd1)
          ok = (f7 == 7'h00);
        else if (f3 == 3'd5)
          ok = (f7 == 7'h00) || (f7 == 7'h20);
        else
          ok = 1'b1;
      end
      7'b0000011: begin
        dec.cls    = C_LOAD;
        dec.rd_wen = 1'b1;
        dec.imm    = imm_i;
        ok = (f3 != 3'd3) && (f3[2:1] != 2'b11);
      end
      7'b0100011: begin
        dec.cls = C_STORE;
        dec.imm = imm_s;
        ok      = !f3[2] && (f3 != 3'd3);
      end
      7'b1100011: begin
        dec.cls = C_BRANCH;
        dec.imm = imm_b;
        ok      = (f3[2:1] != 2'b01);
        // beq/bne compare by subtraction, the rest by set-less-than
        dec.alu = !f3[2] ? A_SUB : (f3[1] ? A_LTU : A_LT);
      end
      7'b1101111: begin
        dec.cls    = C_JAL;
        dec.rd_wen = 1'b1;
        dec.imm    = imm_j;
        ok         = 1'b1;
      end
      7'b1100111: begin
        dec.cls    = C_JALR;
        dec.rd_wen = 1'b1;
        dec.imm    = imm_i;
        ok         = 1'b1;
      end
      7'b0110111: begin
        dec.cls    = C_LUI;
        dec.rd_wen = 1'b1;
        dec.imm    = imm_u;
        ok         = 1'b1;
      end
      7'b0010111: begin
        dec.cls    = C_AUIPC;
        dec.rd_wen = 1'b1;
        dec.imm    = imm_u;
        ok         = 1'b1;
      end
      7'b1110011: begin
        if (f3 == 3'd0) begin
          dec.cls = C_SYS;
          ok = (rd == 5'd0) && (rs1 == 5'd0) &&
               (f12 == 12'h000 || f12 == 12'h001 ||
                f12 == 12'h302);
        end else begin
          dec.cls    = C_CSR;
          dec.rd_wen = 1'b1;
          dec.imm    = f3[2] ? {27'b0, rs1} : 32'b0;
          ok         = (f3 != 3'd4);
        end
      end
      7'b0001111: begin
        dec.cls = C_FENCE;
        ok      = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok || in_ins[1:0] != 2'b11) begin
      dec.cls     = C_ILL;
      dec.alu     = A_ADD;
      dec.imm     = '0;
      dec.rd_wen  = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= dec;
        wptr      <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  entry_t head;

  // empty buffer presents an all-zero bundle
  assign head = out_valid ? mem[rptr] : '0;

  assign out_pc      = head.pc;
  assign out_ins     = head.ins;
  assign out_class   = head.cls;
  assign out_alu_op  = head.alu;
  assign out_imm     = head.imm;
  assign out_rs1     = head.ins[19:15];
  assign out_rs2     = head.ins[24:20];
  assign out_rd      = head.ins[11:7];
  assign out_funct3  = head.ins[14:12];
  assign out_rd_wen  = head.rd_wen;
  assign out_illegal = head.illegal;

endmodule
